// File: rtl/crono_pkg.sv
// Shared types and derived timing constants for the race sequencer.
package crono_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRunning  = 2'd1,
        StFinished = 2'd2,
        StAborted  = 2'd3
    } estado_t;

    function automatic int unsigned ms_tick_clks(input int unsigned clk_freq_hz);
        return clk_freq_hz / 1000;
    endfunction

    function automatic int unsigned debounce_clks(input int unsigned clk_freq_hz,
                                                  input int unsigned debounce_ms);
        return clk_freq_hz / 1000 * debounce_ms;
    endfunction

endpackage

// File: rtl/antirrebote.sv
// Two-flop synchroniser, consecutive-mismatch debouncer and one-clock rising-edge pulse.
module antirrebote #(
    parameter int unsigned DEBOUNCE_CLKS = 250_000
) (
    input  logic clk,
    input  logic reset,
    input  logic entrada,
    output logic pulso
);

    localparam int unsigned CNT_W = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLKS - 1);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic             prev_q;
    logic             pulso_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            pulso_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], entrada};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            prev_q   <= stable_q;
            pulso_q  <= stable_q & ~prev_q;
        end
    end

    assign pulso = pulso_q;

endmodule

// File: rtl/secuenciador_carrera.sv
// Race sequencer: debounced start/finish inputs, race FSM, ms timer and flag command.
// Optional timeout to ABORTED at MAX_RACE_MS is enabled by defining CRONO_TIMEOUT_EN.
module secuenciador_carrera
    import crono_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 25_000_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned MIN_LAP_MS  = 2000,
    parameter int unsigned MAX_RACE_MS = 600_000,
    parameter int unsigned TIME_BITS   = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_start,
    input  logic                 sensor_meta,
    output logic                 comando_banderin,
    output logic                 carrera_activa,
    output logic [TIME_BITS-1:0] tiempo_ms,
    output logic                 tiempo_valido,
    output logic                 fin_pulso,
    output logic [1:0]           estado
);

    localparam int unsigned MS_TICK_CLKS = ms_tick_clks(CLK_FREQ_HZ);
    localparam int unsigned DB_CLKS      = debounce_clks(CLK_FREQ_HZ, DEBOUNCE_MS);
    localparam int unsigned PRESC_W      = (MS_TICK_CLKS > 1) ? $clog2(MS_TICK_CLKS) : 1;

    localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(MS_TICK_CLKS - 1);
    localparam logic [TIME_BITS-1:0] MIN_LAP    = TIME_BITS'(MIN_LAP_MS);
    localparam logic [TIME_BITS-1:0] MAX_RACE   = TIME_BITS'(MAX_RACE_MS);
    localparam logic [TIME_BITS-1:0] TIEMPO_MAX = '1;

`ifdef CRONO_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic start_pulse, sensor_pulse;

    antirrebote #(
        .DEBOUNCE_CLKS(DB_CLKS)
    ) u_db_start (
        .clk    (clk),
        .reset  (reset),
        .entrada(btn_start),
        .pulso  (start_pulse)
    );

    antirrebote #(
        .DEBOUNCE_CLKS(DB_CLKS)
    ) u_db_sensor (
        .clk    (clk),
        .reset  (reset),
        .entrada(sensor_meta),
        .pulso  (sensor_pulse)
    );

    estado_t              estado_q, estado_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [TIME_BITS-1:0] tiempo_q, tiempo_d;
    logic [TIME_BITS-1:0] tiempo_inc;
    logic                 ms_wrap, valid_hit, timeout_hit;
    logic                 flag_q, valido_q, fin_q;

    always_comb begin
        estado_d    = estado_q;
        presc_d     = presc_q;
        tiempo_d    = tiempo_q;
        ms_wrap     = (presc_q == PRESC_LAST);
        tiempo_inc  = (tiempo_q == TIEMPO_MAX) ? tiempo_q : tiempo_q + 1'b1;
        valid_hit   = sensor_pulse && (tiempo_q >= MIN_LAP);
        timeout_hit = TIMEOUT_EN && ms_wrap && (tiempo_inc == MAX_RACE);

        unique case (estado_q)
            StIdle: begin
                if (start_pulse) estado_d = StRunning;
            end
            StRunning: begin
                presc_d = ms_wrap ? '0 : presc_q + 1'b1;
                if (ms_wrap) tiempo_d = tiempo_inc;
                // Finish outranks both manual abort and timeout on the same edge.
                if (valid_hit) begin
                    estado_d = StFinished;
                end else if (start_pulse || timeout_hit) begin
                    estado_d = StAborted;
                end
            end
            StFinished, StAborted: begin
                if (start_pulse) estado_d = StRunning;
            end
            default: estado_d = StIdle;
        endcase

        if (estado_d == StRunning && estado_q != StRunning) begin
            presc_d  = '0;
            tiempo_d = '0;
        end
        if (estado_d != StRunning) presc_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= StIdle;
            presc_q  <= '0;
            tiempo_q <= '0;
            flag_q   <= 1'b0;
            valido_q <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            presc_q  <= presc_d;
            tiempo_q <= tiempo_d;
            flag_q   <= (estado_d == StRunning);
            valido_q <= (estado_d == StFinished);
            fin_q    <= (estado_d == StFinished) && (estado_q != StFinished);
        end
    end

    assign comando_banderin = flag_q;
    assign carrera_activa   = flag_q;
    assign tiempo_ms        = tiempo_q;
    assign tiempo_valido    = valido_q;
    assign fin_pulso        = fin_q;
    assign estado           = estado_q;

endmodule

// File: tb/tb_secuenciador_carrera.sv
// Scoreboard bench: expected state transitions are queued by each scenario and checked on change.
module tb_secuenciador_carrera;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_start, sensor_meta, btn2, sensor2;
    logic        comando_banderin, carrera_activa, tiempo_valido, fin_pulso;
    logic [19:0] tiempo_ms;
    logic [1:0]  estado;
    logic        cmd2, act2, val2, fin2;
    logic [5:0]  tiempo2;
    logic [1:0]  estado2;

    always #5 clk = ~clk;

    secuenciador_carrera #(
        .CLK_FREQ_HZ(10_000), .DEBOUNCE_MS(1), .MIN_LAP_MS(5), .MAX_RACE_MS(50), .TIME_BITS(20)
    ) dut (
        .clk(clk), .reset(reset), .btn_start(btn_start), .sensor_meta(sensor_meta),
        .comando_banderin(comando_banderin), .carrera_activa(carrera_activa),
        .tiempo_ms(tiempo_ms), .tiempo_valido(tiempo_valido), .fin_pulso(fin_pulso),
        .estado(estado)
    );

    secuenciador_carrera #(
        .CLK_FREQ_HZ(10_000), .DEBOUNCE_MS(1), .MIN_LAP_MS(5), .MAX_RACE_MS(50), .TIME_BITS(6)
    ) dut_sat (
        .clk(clk), .reset(reset), .btn_start(btn2), .sensor_meta(sensor2),
        .comando_banderin(cmd2), .carrera_activa(act2), .tiempo_ms(tiempo2),
        .tiempo_valido(val2), .fin_pulso(fin2), .estado(estado2)
    );

    typedef struct {
        logic [1:0] est;
        int         tmin;
        int         tmax;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] prev_est = 2'd0;
    int         t_obs;

    // Every estado change outside reset must match the next queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            prev_est = 2'd0;
        end else if (estado !== prev_est) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: estado=%0d, no transition was expected", estado);
            end else begin
                e = sb.pop_front();
                t_obs = int'(tiempo_ms);
                if (estado !== e.est || t_obs < e.tmin || t_obs > e.tmax) begin
                    n_err++;
                    $display("FAIL sb_transition: estado=%0d tiempo=%0d, required estado=%0d tiempo %0d..%0d",
                             estado, t_obs, e.est, e.tmin, e.tmax);
                end
                n_cmp++;
                if (comando_banderin !== (e.est == 2'd1) || carrera_activa !== (e.est == 2'd1) ||
                    tiempo_valido !== (e.est == 2'd2) || fin_pulso !== (e.est == 2'd2)) begin
                    n_err++;
                    $display("FAIL sb_outputs: cmd=%b act=%b val=%b fin=%b for estado %0d",
                             comando_banderin, carrera_activa, tiempo_valido, fin_pulso, e.est);
                end
            end
            prev_est = estado;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string name);
        int k = 0;
        while (estado !== s && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (estado !== s) begin
            n_err++;
            $display("FAIL %s: estado=%0d required=%0d", name, estado, s);
        end
    endtask

    task automatic wait_tiempo(input int t, input int budget, input string name);
        int k = 0;
        while (int'(tiempo_ms) < t && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (int'(tiempo_ms) < t) begin
            n_err++;
            $display("FAIL %s: tiempo=%0d required>=%0d", name, tiempo_ms, t);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            btn_start   = ~btn_start;
            sensor_meta = (i % 3 == 0) ? ~sensor_meta : sensor_meta;
            n_cmp++;
            if (estado !== 2'd0 || comando_banderin !== 1'b0 || tiempo_ms !== 20'd0 ||
                tiempo_valido !== 1'b0 || fin_pulso !== 1'b0 || estado2 !== 2'd0) begin
                n_err++;
                $display("FAIL reset_hold: est=%0d cmd=%b t=%0d val=%b fin=%b, required all 0",
                         estado, comando_banderin, tiempo_ms, tiempo_valido, fin_pulso);
            end
        end
        btn_start   = 1'b0;
        sensor_meta = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(20);
        n_cmp++;
        if (estado !== 2'd0 || comando_banderin !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: est=%0d cmd=%b, required 0/0", estado, comando_banderin);
        end
    endtask

    task automatic test_bounce_start();
        sb.push_back('{2'd1, 0, 0});
        for (int i = 0; i < 10; i++) begin
            btn_start = ~btn_start;
            tick(3);
        end
        n_cmp++;
        if (estado !== 2'd0) begin
            n_err++;
            $display("FAIL bounce_ignored: estado=%0d required=0", estado);
        end
        btn_start = 1'b1;
        wait_state(2'd1, 40, "bounce_enter_running");
        n_cmp++;
        if (tiempo_ms !== 20'd0 || comando_banderin !== 1'b1) begin
            n_err++;
            $display("FAIL run_entry: tiempo=%0d cmd=%b, required 0/1", tiempo_ms, comando_banderin);
        end
        for (int k = 1; k <= 3; k++) begin
            tick(10);
            n_cmp++;
            if (tiempo_ms !== 20'(k)) begin
                n_err++;
                $display("FAIL ms_count: tiempo=%0d required=%0d", tiempo_ms, k);
            end
        end
        btn_start = 1'b0;
        tick(30);
        n_cmp++;
        if (estado !== 2'd1) begin
            n_err++;
            $display("FAIL release_no_event: estado=%0d required=1", estado);
        end
    endtask

    task automatic test_abort();
        sb.push_back('{2'd3, 0, 1000});
        btn_start = 1'b1;
        wait_state(2'd3, 30, "abort_enter");
        n_cmp++;
        if (comando_banderin !== 1'b0 || tiempo_valido !== 1'b0) begin
            n_err++;
            $display("FAIL abort_outputs: cmd=%b val=%b, required 0/0", comando_banderin, tiempo_valido);
        end
        btn_start = 1'b0;
        tick(20);
        sb.push_back('{2'd1, 0, 0});
        btn_start = 1'b1;
        wait_state(2'd1, 30, "restart_after_abort");
        n_cmp++;
        if (tiempo_ms !== 20'd0) begin
            n_err++;
            $display("FAIL restart_time: tiempo=%0d required=0", tiempo_ms);
        end
        btn_start = 1'b0;
        tick(20);
    endtask

    task automatic test_sensor_finish();
        int k = 0;
        wait_tiempo(2, 100, "reach_2ms");
        sensor_meta = 1'b1;
        tick(20);
        sensor_meta = 1'b0;
        tick(20);
        n_cmp++;
        if (estado !== 2'd1) begin
            n_err++;
            $display("FAIL early_sensor_ignored: estado=%0d required=1", estado);
        end
        wait_tiempo(18, 250, "reach_18ms");
        sb.push_back('{2'd2, 19, 21});
        sensor_meta = 1'b1;
        while (fin_pulso !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (fin_pulso !== 1'b1) begin
            n_err++;
            $display("FAIL fin_pulse_seen: fin_pulso=%b required=1", fin_pulso);
        end
        tick(1);
        n_cmp++;
        if (fin_pulso !== 1'b0 || estado !== 2'd2) begin
            n_err++;
            $display("FAIL fin_one_clk: fin=%b est=%0d, required 0/2", fin_pulso, estado);
        end
        tick(20);
        sensor_meta = 1'b0;
        tick(20);
        sensor_meta = 1'b1;
        tick(20);
        sensor_meta = 1'b0;
        tick(20);
        n_cmp++;
        if (estado !== 2'd2 || tiempo_valido !== 1'b1 || comando_banderin !== 1'b0 ||
            tiempo_ms < 20'd19 || tiempo_ms > 20'd21) begin
            n_err++;
            $display("FAIL finished_hold: est=%0d val=%b cmd=%b t=%0d, required 2/1/0/19..21",
                     estado, tiempo_valido, comando_banderin, tiempo_ms);
        end
    endtask

    task automatic test_timeout_saturation();
        int k = 0;
        btn2 = 1'b1;
        while (estado2 !== 2'd1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (estado2 !== 2'd1 || tiempo2 !== 6'd0) begin
            n_err++;
            $display("FAIL sat_start: est=%0d t=%0d, required 1/0", estado2, tiempo2);
        end
        btn2 = 1'b0;
`ifdef CRONO_TIMEOUT_EN
        k = 0;
        while (estado2 !== 2'd3 && k < 700) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (estado2 !== 2'd3 || tiempo2 !== 6'd50 || cmd2 !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_abort: est=%0d t=%0d cmd=%b, required 3/50/0", estado2, tiempo2, cmd2);
        end
        n_cmp++;
        if (k < 495 || k > 505) begin
            n_err++;
            $display("FAIL timeout_cycle: took %0d clks, required about 500", k);
        end
`else
        tick(700);
        n_cmp++;
        if (estado2 !== 2'd1 || tiempo2 !== 6'd63 || cmd2 !== 1'b1) begin
            n_err++;
            $display("FAIL saturate: est=%0d t=%0d cmd=%b, required 1/63/1", estado2, tiempo2, cmd2);
        end
        tick(50);
        n_cmp++;
        if (tiempo2 !== 6'd63) begin
            n_err++;
            $display("FAIL saturate_hold: t=%0d required=63", tiempo2);
        end
`endif
    endtask

    task automatic test_reset_mid_race();
        int k = 0;
        sb.push_back('{2'd1, 0, 0});
        btn_start = 1'b1;
        wait_state(2'd1, 30, "race_for_reset");
        btn_start = 1'b0;
        while (tiempo_ms !== 20'd30 && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (tiempo_ms !== 20'd30) begin
            n_err++;
            $display("FAIL reach_30ms: tiempo=%0d required=30", tiempo_ms);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (estado !== 2'd0 || comando_banderin !== 1'b0 || tiempo_ms !== 20'd0 ||
            carrera_activa !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: est=%0d cmd=%b t=%0d, required 0/0/0",
                     estado, comando_banderin, tiempo_ms);
        end
        tick(3);
        reset = 1'b0;
        tick(5);
    endtask

    initial begin
        reset       = 1'b1;
        btn_start   = 1'b0;
        sensor_meta = 1'b0;
        btn2        = 1'b0;
        sensor2     = 1'b0;
        test_reset();
        test_bounce_start();
        test_abort();
        test_sensor_finish();
        test_timeout_saturation();
        test_reset_mid_race();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d expected transitions never seen, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/secuenciador_carrera.md
Name: secuenciador_carrera

Overview:
- Race sequencer sitting directly upstream of the flag servo PWM generator; its comando_banderin output drives that block's command input.
- Takes the raw start pushbutton and the raw finish-line sensor, synchronises and debounces both, and runs a race state machine.
- Measures elapsed race time in milliseconds from the 25 MHz clock and raises the flag (command=1) only while a race is running.

Parameters:
- CLK_FREQ_HZ, 25_000_000, system clock frequency; ms prescaler terminal = CLK_FREQ_HZ/1000.
- DEBOUNCE_MS, 10, stability window for both inputs; DEBOUNCE_CLKS = CLK_FREQ_HZ/1000*DEBOUNCE_MS.
- MIN_LAP_MS, 2000, sensor blanking after start; hits with tiempo_ms < MIN_LAP_MS are ignored.
- MAX_RACE_MS, 600_000, timeout used only with the optional feature.
- TIME_BITS, 20, width of tiempo_ms.

Ports:
- clk in 1: system clock.
- reset in 1: asynchronous, active-high.
- btn_start in 1: raw start/abort pushbutton, asynchronous, active-high.
- sensor_meta in 1: raw finish-line sensor, asynchronous, 1 = line crossed.
- comando_banderin out 1: 1 = flag up (90°), 0 = flag down (0°).
- carrera_activa out 1: high in RUNNING.
- tiempo_ms out TIME_BITS: elapsed/final race time in ms.
- tiempo_valido out 1: high in FINISHED only.
- fin_pulso out 1: one-clk pulse on entry to FINISHED.
- estado out 2: IDLE=0, RUNNING=1, FINISHED=2, ABORTED=3.

Behaviour:
- Reset (async): estado=IDLE; all outputs 0; sync FFs, debounce state, prescaler and tiempo_ms all 0.
- Input path, per input:
  - 2-FF synchroniser.
  - Debounce counter counts consecutive clocks where the sync value differs from the stable value; any match clears it. At DEBOUNCE_CLKS consecutive mismatches, stable takes the sync value and the counter clears.
  - Registered rising-edge pulse (stable & ~stable_prev), one clk wide. Falling edges produce no event.
- FSM, registered; acts on the clk edge where a pulse is high:
  - IDLE: start_pulse -> RUNNING.
  - RUNNING:
    - sensor_pulse with tiempo_ms >= MIN_LAP_MS -> FINISHED.
    - sensor_pulse with tiempo_ms < MIN_LAP_MS: ignored.
    - start_pulse -> ABORTED (manual abort).
    - Simultaneous valid sensor_pulse and start_pulse: FINISHED wins.
  - FINISHED / ABORTED: start_pulse -> RUNNING (new race); sensor ignored.
- Timing:
  - On every transition into RUNNING: prescaler=0, tiempo_ms=0 (same edge).
  - In RUNNING the prescaler counts 0..CLK_FREQ_HZ/1000-1 and wraps; the wrap cycle increments tiempo_ms.
  - tiempo_ms saturates at 2^TIME_BITS-1 (no wrap).
  - Outside RUNNING, tiempo_ms holds its value and the prescaler holds 0.
- Outputs, all registered, updating on the same edge as estado:
  - comando_banderin = carrera_activa = (estado==RUNNING).
  - tiempo_valido = (estado==FINISHED).
  - fin_pulso high for exactly the first clk of FINISHED.
- Reset mid-race: immediate return to IDLE, flag drops asynchronously, time cleared.

Optional Feature:
- Macro: CRONO_TIMEOUT_EN.
- Defined: in RUNNING, on the edge where tiempo_ms would reach MAX_RACE_MS, estado -> ABORTED with tiempo_ms = MAX_RACE_MS. A valid sensor_pulse on that same edge takes priority (FINISHED).
- Undefined: no timeout; the race runs until sensor or abort, and tiempo_ms saturates.

Decomposition:
- Package crono_pkg: estado_t enum (IDLE/RUNNING/FINISHED/ABORTED, 2-bit encoding above) and the derived constants MS_TICK_CLKS and DEBOUNCE_CLKS (as functions of parameters).
- One sub-module, antirrebote: synchroniser + debounce + rising-edge pulse, parameterised by DEBOUNCE_CLKS, instantiated twice.

Test Plan (CLK_FREQ_HZ=10_000, DEBOUNCE_MS=1, MIN_LAP_MS=5, MAX_RACE_MS=50, TIME_BITS=20 unless noted):
- Reset asserted with inputs toggling -> estado=0, comando_banderin=0, tiempo_ms=0, tiempo_valido=0, fin_pulso=0 throughout.
- btn_start toggles every 3 clks for 30 clks then holds 1 -> exactly one entry to RUNNING; comando_banderin=1; tiempo_ms=0 then +1 every 10 clks; release causes no event.
- Start, then sensor pulse (held 20 clks) at ~2 ms -> ignored, still RUNNING. Sensor again at ~20 ms -> FINISHED; fin_pulso 1 clk; comando_banderin=0; tiempo_ms frozen in 19..21; tiempo_valido=1.
- Start pressed again in RUNNING -> ABORTED (estado=3), flag 0, tiempo_valido=0. Next press -> RUNNING with tiempo_ms=0.
- With CRONO_TIMEOUT_EN, no sensor -> ABORTED exactly when tiempo_ms=50. Without the macro and TIME_BITS=6 -> tiempo_ms reaches 63 and holds, still RUNNING.
- Reset asserted at tiempo_ms=30 -> same cycle: estado=IDLE, comando_banderin=0, tiempo_ms=0.
